// File: rtl/tone_pkg.sv
// Shared types and constants for the tone sequencer: FSM encoding, song selection
// and note half-periods for a 50 MHz board clock.
package tone_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

    // Selects which table song_rom plays; SONG_TEST is a short 3-note bring-up song.
    typedef enum logic {
        SONG_DEMO = 1'b0,
        SONG_TEST = 1'b1
    } song_e;

    localparam int unsigned NOTE_C = 47_774;
    localparam int unsigned NOTE_D = 42_568;
    localparam int unsigned NOTE_E = 37_919;
    localparam int unsigned NOTE_F = 35_791;
    localparam int unsigned NOTE_G = 31_888;
    localparam int unsigned REST   = 0;

endpackage

// File: rtl/tone_sequencer_if.sv
// Control/status bundle between the tone sequencer and its controller.
interface tone_sequencer_if #(
    parameter int unsigned IDX_W = 7
);
    logic             iSTART;
    logic             iSTOP;
    logic             iLOOP;
    logic             oSOUND;
    logic             oBUSY;
    logic             oDONE;
    logic [IDX_W-1:0] oIDX;

    modport slave (
        input  iSTART, iSTOP, iLOOP,
        output oSOUND, oBUSY, oDONE, oIDX
    );

    modport master (
        output iSTART, iSTOP, iLOOP,
        input  oSOUND, oBUSY, oDONE, oIDX
    );
endinterface

// File: rtl/song_rom.sv
// Song table: combinational lookup of {half-period, duration} for a note index.
// Indices at or beyond NOTES read as a one-tick rest.
module song_rom
    import tone_pkg::*;
#(
    parameter int unsigned NOTES  = 75,
    parameter int unsigned IDX_W  = 7,
    parameter int unsigned DUR_W  = 4,
    parameter int unsigned HALF_W = 21,
    parameter song_e       SONG   = SONG_DEMO
) (
    input  logic [IDX_W-1:0]  iIDX,
    output logic [HALF_W-1:0] oHALF,
    output logic [DUR_W-1:0]  oDUR
);

    int unsigned half_v;
    int unsigned dur_v;
    int unsigned phrase;

    always_comb begin
        half_v = REST;
        dur_v  = 1;
        phrase = 32'(iIDX) % 32'd15;
        if (32'(iIDX) < NOTES) begin
            if (SONG == SONG_TEST) begin
                case (32'(iIDX))
                    0:       begin half_v = 2;    dur_v = 1; end
                    1:       begin half_v = REST; dur_v = 2; end
                    2:       begin half_v = 3;    dur_v = 0; end
                    default: begin half_v = REST; dur_v = 1; end
                endcase
            end else begin
                // Demo song: a 15-note phrase repeated over the whole table.
                case (phrase)
                    0, 1, 6, 11, 12: half_v = NOTE_E;
                    2, 5:            half_v = NOTE_F;
                    3, 4:            half_v = NOTE_G;
                    7, 10, 13, 14:   half_v = NOTE_D;
                    8, 9:            half_v = NOTE_C;
                    default:         half_v = REST;
                endcase
                case (phrase)
                    12:      dur_v = 3;
                    13:      dur_v = 1;
                    14:      dur_v = 4;
                    default: dur_v = 2;
                endcase
            end
        end
        oHALF = HALF_W'(half_v);
        oDUR  = DUR_W'(dur_v);
    end

endmodule

// File: rtl/tone_sequencer.sv
// Melody player: walks the song table, timing each note in ticks and emitting a
// square wave on oSOUND. Start/stop control, optional looping and a done pulse.
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int unsigned TICK_DIV = 6_250_000,
    parameter int unsigned NOTES    = 75,
    parameter int unsigned IDX_W    = 7,
    parameter int unsigned DUR_W    = 4,
    parameter int unsigned HALF_W   = 21,
    parameter song_e       SONG     = SONG_DEMO
) (
    input logic             iCLK,
    input logic             iRST,
    tone_sequencer_if.slave bus
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_e              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [HALF_W-1:0]   tone_q, tone_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                sound_q, sound_d;
    logic                done_q, done_d;

    logic [HALF_W-1:0]   rom_half;
    logic [DUR_W-1:0]    rom_dur;
    logic [DUR_W-1:0]    dur_last;
    logic                tick;
    logic                note_end;

    song_rom #(
        .NOTES  (NOTES),
        .IDX_W  (IDX_W),
        .DUR_W  (DUR_W),
        .HALF_W (HALF_W),
        .SONG   (SONG)
    ) u_rom (
        .iIDX  (idx_q),
        .oHALF (rom_half),
        .oDUR  (rom_dur)
    );

    // A zero duration plays as a single tick.
    assign dur_last = (rom_dur == '0) ? '0 : rom_dur - 1'b1;
    assign tick     = (tick_q == TICK_W'(TICK_DIV - 1));
    assign note_end = tick && (dur_q == dur_last);

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path can infer a latch.
        state_d = state_q;
        tick_d  = '0;
        dur_d   = '0;
        tone_d  = '0;
        idx_d   = '0;
        sound_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.iSTART && !bus.iSTOP) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (bus.iSTOP) begin
                    state_d = ST_IDLE;
                end else begin
                    tick_d = tick ? '0 : tick_q + 1'b1;
                    dur_d  = dur_q;
                    idx_d  = idx_q;
                    if (rom_half != '0) begin
                        if (tone_q == rom_half - 1'b1) begin
                            sound_d = ~sound_q;
                        end else begin
                            tone_d  = tone_q + 1'b1;
                            sound_d = sound_q;
                        end
                    end
                    if (note_end) begin
                        dur_d   = '0;
                        tone_d  = '0;
                        sound_d = 1'b0;
                        if (idx_q == IDX_W'(NOTES - 1)) begin
                            idx_d = '0;
                            if (!bus.iLOOP) begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else if (tick) begin
                        dur_d = dur_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            dur_q   <= '0;
            tone_q  <= '0;
            idx_q   <= '0;
            sound_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            dur_q   <= dur_d;
            tone_q  <= tone_d;
            idx_q   <= idx_d;
            sound_q <= sound_d;
            done_q  <= done_d;
        end
    end

    assign bus.oSOUND = sound_q;
    assign bus.oBUSY  = (state_q == ST_PLAY);
    assign bus.oDONE  = done_q;
    assign bus.oIDX   = idx_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer using the 3-note test song and a 4-cycle tick.
module tb_tone_sequencer;
    import tone_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic saw_done;
    logic saw_idle;

    // Expected per-cycle outputs after the start edge: note 0 (4 cycles, half=2),
    // note 1 (8 cycles, rest), note 2 (4 cycles, half=3), then done and idle.
    int exp_idx [18] = '{0,0,0,0, 1,1,1,1,1,1,1,1, 2,2,2,2, 0,0};
    int exp_snd [18] = '{0,0,1,1, 0,0,0,0,0,0,0,0, 0,0,0,1, 0,0};

    always #5 clk = ~clk;

    tone_sequencer_if #(.IDX_W(2)) tif ();

    tone_sequencer #(
        .TICK_DIV (4),
        .NOTES    (3),
        .IDX_W    (2),
        .DUR_W    (4),
        .HALF_W   (21),
        .SONG     (SONG_TEST)
    ) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (tif)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " sound"}, 32'(tif.oSOUND), 0);
        check({tag, " busy"},  32'(tif.oBUSY),  0);
        check({tag, " done"},  32'(tif.oDONE),  0);
        check({tag, " idx"},   32'(tif.oIDX),   0);
    endtask

    task automatic start_pulse();
        tif.iSTART = 1'b1;
        step();
        tif.iSTART = 1'b0;
    endtask

    // Plays the whole song with iLOOP=0; optionally re-pulses iSTART after cycle restart_k.
    task automatic play_and_check(input string tag, input int restart_k);
        start_pulse();
        for (int k = 0; k < 18; k++) begin
            check($sformatf("%s idx c%0d", tag, k),   32'(tif.oIDX),   exp_idx[k]);
            check($sformatf("%s sound c%0d", tag, k), 32'(tif.oSOUND), exp_snd[k]);
            check($sformatf("%s busy c%0d", tag, k),  32'(tif.oBUSY),  (k < 16) ? 1 : 0);
            check($sformatf("%s done c%0d", tag, k),  32'(tif.oDONE),  (k == 16) ? 1 : 0);
            tif.iSTART = (k == restart_k);
            step();
        end
        tif.iSTART = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        tif.iSTART = 1'b0;
        tif.iSTOP  = 1'b0;
        tif.iLOOP  = 1'b0;

        // Reset, then a long idle stretch.
        step();
        step();
        check_idle("reset");
        rst = 1'b0;
        repeat (20) step();
        check_idle("idle");

        // Single non-looped playback.
        play_and_check("song", -1);

        // Looping: 2 -> 0 with no gap, busy held, no done.
        tif.iLOOP = 1'b1;
        start_pulse();
        saw_done = 1'b0;
        saw_idle = 1'b0;
        for (int k = 0; k < 36; k++) begin
            if (tif.oDONE) saw_done = 1'b1;
            if (!tif.oBUSY) saw_idle = 1'b1;
            if (k == 15) check("loop idx c15", 32'(tif.oIDX), 2);
            if (k == 16) check("loop idx c16", 32'(tif.oIDX), 0);
            if (k == 18) check("loop sound c18", 32'(tif.oSOUND), 1);
            if (k == 20) check("loop idx c20", 32'(tif.oIDX), 1);
            if (k == 32) check("loop idx c32", 32'(tif.oIDX), 0);
            step();
        end
        check("loop no done", 32'(saw_done), 0);
        check("loop busy held", 32'(saw_idle), 0);
        tif.iLOOP = 1'b0;
        tif.iSTOP = 1'b1;
        step();
        tif.iSTOP = 1'b0;
        check_idle("loop stop");

        // Stop in the middle of note 0 while the tone is high, then restart.
        start_pulse();
        step();
        step();
        check("stop pre sound", 32'(tif.oSOUND), 1);
        tif.iSTOP = 1'b1;
        step();
        tif.iSTOP = 1'b0;
        check_idle("stop");
        repeat (3) step();
        check_idle("stop after");
        start_pulse();
        check("restart idx", 32'(tif.oIDX), 0);
        check("restart busy", 32'(tif.oBUSY), 1);
        step();
        step();
        check("restart sound", 32'(tif.oSOUND), 1);
        step();
        step();
        check("restart idx note1", 32'(tif.oIDX), 1);
        tif.iSTOP = 1'b1;
        step();
        tif.iSTOP = 1'b0;
        check_idle("restart stop");

        // Start and stop together in idle stays idle; a second start during play is ignored.
        tif.iSTART = 1'b1;
        tif.iSTOP  = 1'b1;
        step();
        tif.iSTART = 1'b0;
        tif.iSTOP  = 1'b0;
        check_idle("start+stop");
        step();
        check_idle("start+stop after");
        play_and_check("restart-ignored", 2);

        // Reset during note 2, on the edge that would have ended the song.
        start_pulse();
        repeat (15) step();
        check("pre-rst idx", 32'(tif.oIDX), 2);
        check("pre-rst sound", 32'(tif.oSOUND), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("rst mid");

        // Stop coinciding with the last-note end tick: no done pulse.
        start_pulse();
        repeat (15) step();
        check("pre-stop idx", 32'(tif.oIDX), 2);
        tif.iSTOP = 1'b1;
        step();
        tif.iSTOP = 1'b0;
        check_idle("stop at end");
        step();
        check_idle("stop at end after");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
